// File: rtl/lms_sequencer_pkg.sv
// Shared state encoding, strobe-bundle indices and loop helpers for the LMS pass sequencer.
package lms_sequencer_pkg;
  localparam int FIR_LENGTH_DEF = 16;
  localparam int CNT_W_DEF      = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STORE  = 3'd1,
    S_FILL   = 3'd2,
    S_FILTER = 3'd3,
    S_OUTPUT = 3'd4,
    S_ADAPT  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam int NUM_STB           = 10;
  localparam int STB_READ_MAIN     = 0;
  localparam int STB_READ_SUB      = 1;
  localparam int STB_CLR_I         = 2;
  localparam int STB_INC_I         = 3;
  localparam int STB_INC_PTR       = 4;
  localparam int STB_WRITE_NEW_MEM = 5;
  localparam int STB_UPDATE_MEM    = 6;
  localparam int STB_COMPUTE_ERROR = 7;
  localparam int STB_WEIGHT_UPDATE = 8;
  localparam int STB_WRITE_OUTPUT  = 9;

  function automatic logic is_loop_state(input state_t s);
    return (s == S_FILL) || (s == S_FILTER) || (s == S_ADAPT);
  endfunction

  function automatic state_t loop_exit(input state_t s);
    case (s)
      S_FILL:   return S_FILTER;
      S_FILTER: return S_OUTPUT;
      default:  return S_FINISH;
    endcase
  endfunction
endpackage

// File: rtl/lms_sequencer_if.sv
// Handshake, datapath status and strobe bundle between the sequencer (master) and the datapath side (slave).
interface lms_sequencer_if;
  logic sample_valid;
  logic sample_ready;
  logic adapt_en;
  logic clear_fault;
  logic i_equal_fir_length;
  logic i_equal_fir_length_minus_1;
  logic read_main;
  logic read_sub;
  logic clr_i;
  logic inc_i;
  logic inc_ptr;
  logic write_new_mem;
  logic update_mem;
  logic compute_error;
  logic weight_update;
  logic write_output;
  logic out_valid;
  logic busy;
  logic overrun;
  logic fault;

  modport master (
    input  sample_valid, adapt_en, clear_fault,
           i_equal_fir_length, i_equal_fir_length_minus_1,
    output sample_ready, read_main, read_sub, clr_i, inc_i, inc_ptr,
           write_new_mem, update_mem, compute_error, weight_update, write_output,
           out_valid, busy, overrun, fault
  );

  modport slave (
    output sample_valid, adapt_en, clear_fault,
           i_equal_fir_length, i_equal_fir_length_minus_1,
    input  sample_ready, read_main, read_sub, clr_i, inc_i, inc_ptr,
           write_new_mem, update_mem, compute_error, weight_update, write_output,
           out_valid, busy, overrun, fault
  );
endinterface

// File: rtl/lms_loop_watchdog.sv
// Per-loop cycle counter: flags a loop that overstays FIR_LENGTH+1 cycles, or an index that
// reaches FIR_LENGTH without passing through FIR_LENGTH-1 on the previous loop cycle.
module lms_loop_watchdog
  import lms_sequencer_pkg::*;
#(
  parameter int FIR_LENGTH = FIR_LENGTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_eq,
  input  logic i_eq_m1,
  output logic o_expire,
  output logic o_seq_err
);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FIR_LENGTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_prev_m1;
  logic             w_exit;

  assign o_expire  = i_en & ~i_eq & (r_cnt == CNT_LIMIT);
  assign o_seq_err = i_en & i_eq & ~r_prev_m1;
  // Leaving the loop (or not being in one) rearms the counter for the next loop entry.
  assign w_exit    = ~i_en | i_eq | o_expire;

  always_ff @(posedge clk) begin
    if (rst || w_exit) begin
      r_cnt     <= '0;
      r_prev_m1 <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_prev_m1 <= i_eq_m1;
    end
  end
endmodule

// File: rtl/lms_sequencer.sv
// Control FSM for one LMS adaptive-filter pass per accepted sample pair; Mealy datapath strobes,
// registered out_valid, sticky overrun/fault flags and loop watchdog abort.
module lms_sequencer
  import lms_sequencer_pkg::*;
#(
  parameter int FIR_LENGTH = FIR_LENGTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  lms_sequencer_if.master bus
);
  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_STB-1:0] w_stb;
  logic               r_adapt;
  logic               r_out_valid;
  logic               r_overrun;
  logic               r_fault;
  logic               w_ready;
  logic               w_accept;
  logic               w_loop;
  logic               w_expire;
  logic               w_seq_err;
  logic               w_abort;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = bus.sample_valid & w_ready;
  assign w_loop   = is_loop_state(r_state);
  assign w_abort  = w_expire | w_seq_err;

  lms_loop_watchdog #(.FIR_LENGTH(FIR_LENGTH), .CNT_W(CNT_W)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_loop),
    .i_eq      (bus.i_equal_fir_length),
    .i_eq_m1   (bus.i_equal_fir_length_minus_1),
    .o_expire  (w_expire),
    .o_seq_err (w_seq_err)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stb       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_stb[STB_READ_MAIN] = 1'b1;
          w_stb[STB_READ_SUB]  = 1'b1;
          w_stb[STB_CLR_I]     = 1'b1;
          w_state_nxt          = S_STORE;
        end
      end
      S_STORE: begin
        w_stb[STB_WRITE_NEW_MEM] = 1'b1;
        w_state_nxt              = S_FILL;
      end
      S_FILL, S_FILTER, S_ADAPT: begin
        // Ops are gated by !i_equal so the datapath never touches tap index FIR_LENGTH.
        if (w_abort) begin
          w_stb[STB_CLR_I] = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (bus.i_equal_fir_length) begin
          w_stb[STB_CLR_I] = 1'b1;
          w_state_nxt      = loop_exit(r_state);
        end else begin
          w_stb[STB_INC_I] = 1'b1;
          if (r_state == S_FILL)        w_stb[STB_UPDATE_MEM]    = 1'b1;
          else if (r_state == S_FILTER) w_stb[STB_COMPUTE_ERROR] = 1'b1;
          else                          w_stb[STB_WEIGHT_UPDATE] = 1'b1;
        end
      end
      S_OUTPUT: begin
        w_stb[STB_WRITE_OUTPUT] = 1'b1;
        w_state_nxt             = r_adapt ? S_ADAPT : S_FINISH;
      end
      S_FINISH: begin
        w_stb[STB_INC_PTR] = 1'b1;
        w_state_nxt        = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A set event in the same cycle as clear_fault wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adapt     <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_out_valid <= (r_state == S_OUTPUT);
      if (w_accept) r_adapt <= bus.adapt_en;
      if (bus.sample_valid & ~w_ready) r_overrun <= 1'b1;
      else if (bus.clear_fault)        r_overrun <= 1'b0;
      if (w_abort)                     r_fault   <= 1'b1;
      else if (bus.clear_fault)        r_fault   <= 1'b0;
    end
  end

  assign bus.sample_ready  = w_ready;
  assign bus.busy          = ~w_ready;
  assign bus.read_main     = w_stb[STB_READ_MAIN];
  assign bus.read_sub      = w_stb[STB_READ_SUB];
  assign bus.clr_i         = w_stb[STB_CLR_I];
  assign bus.inc_i         = w_stb[STB_INC_I];
  assign bus.inc_ptr       = w_stb[STB_INC_PTR];
  assign bus.write_new_mem = w_stb[STB_WRITE_NEW_MEM];
  assign bus.update_mem    = w_stb[STB_UPDATE_MEM];
  assign bus.compute_error = w_stb[STB_COMPUTE_ERROR];
  assign bus.weight_update = w_stb[STB_WEIGHT_UPDATE];
  assign bus.write_output  = w_stb[STB_WRITE_OUTPUT];
  assign bus.out_valid     = r_out_valid;
  assign bus.overrun       = r_overrun;
  assign bus.fault         = r_fault;
endmodule
